data_mem_responder: RTL and testbench

//  Responder for the core's data-memory port. Takes mem_addr/oe/we/wdata requests.

---
 rtl/data_mem_responder_pkg.sv | 56 +++++
 rtl/data_mem_responder_if.sv | 42 ++++
 rtl/data_mem_responder_dmem_bram.sv | 39 +++
 rtl/data_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// =============================================================================
// Module : data_mem_responder_pkg
// Brief  : Shared data-memory interface constants, FSM encoding, lane helpers
// Rev    : 1.0  initial release
// =============================================================================
package data_mem_responder_pkg;

    localparam int unsigned c_io_sel   = 31;
    localparam logic [31:0] c_deadbeef = 32'hDEAD_BEEF;
    localparam int unsigned c_lanes    = 4;

    // Core load funct3 codes; data on the port is always right-aligned.
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    localparam logic [3:0] c_oe_none = 4'b0000;
    localparam logic [3:0] c_oe_byte = 4'b0001;
    localparam logic [3:0] c_oe_half = 4'b0011;
    localparam logic [3:0] c_oe_word = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_DONE = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_IO_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] lane_shift(input logic [3:0] lanes, input logic [1:0] sh);
        return lanes << sh;
    endfunction

    function automatic logic lane_aligned(input logic [3:0] lanes, input logic [1:0] sh);
        logic ok;
        ok = 1'b1;
        case (lanes)
            c_oe_half: ok = ~sh[0];
            c_oe_word: ok = (sh == 2'b00);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] align_right(input logic [31:0] word, input logic [1:0] sh);
        return word >> {sh, 3'b000};
    endfunction

    function automatic logic [31:0] align_lanes(input logic [31:0] word, input logic [1:0] sh);
        return word << {sh, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// =============================================================================
// Module : data_mem_responder_if
// Brief  : Core data port, IO bus and error status bundle
// Rev    : 1.0  initial release
// =============================================================================
interface data_mem_responder_if;

    logic [31:0] mem_addr;
    logic [3:0]  mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;

    logic        io_req;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_we;
    logic [31:0] io_rdata;
    logic        io_ack;

    logic        err_misal;
    logic        err_tmo;
    logic [31:0] err_addr;

    // master: the core plus the IO device it reaches through the responder
    modport master (
        output mem_addr, mem_oe, mem_wdata, mem_we, io_rdata, io_ack,
        input  mem_rdata, mem_valid, mem_ready, io_req, io_addr, io_wdata, io_we,
        input  err_misal, err_tmo, err_addr
    );

    modport slave (
        input  mem_addr, mem_oe, mem_wdata, mem_we, io_rdata, io_ack,
        output mem_rdata, mem_valid, mem_ready, io_req, io_addr, io_wdata, io_we,
        output err_misal, err_tmo, err_addr
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_dmem_bram.sv
`default_nettype none
// =============================================================================
// Module : dmem_bram
// Brief  : Single-port 2^SCALE x 32 RAM, byte write enables, registered read
// Rev    : 1.0  initial release
// =============================================================================
module dmem_bram
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned SCALE = 14
) (
    input  logic               clk,
    input  logic               en,
    input  logic [c_lanes-1:0] we,
    input  logic [SCALE-1:0]   addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] r_mem [2**SCALE];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < c_lanes; b++) begin
                if (we[b]) begin
                    r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (we == '0) begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// =============================================================================
// Module : data_mem_responder
// Brief  : Data-memory responder: internal byte-lane BRAM plus timed IO bridge
// Rev    : 1.0  initial release
// =============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned SCALE   = 14,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned c_cnt_w = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT);

    state_t             r_state;
    logic               r_valid;
    logic               r_ready;
    logic [31:0]        r_rdata;
    logic               r_io_req;
    logic [31:0]        r_io_addr;
    logic [31:0]        r_io_wdata;
    logic [3:0]         r_io_we;
    logic               r_err_misal;
    logic               r_err_tmo;
    logic [31:0]        r_err_addr;
    logic [1:0]         r_sh;
    logic               r_rd_zero;
    logic               r_io_read;
    logic [31:0]        r_req_addr;
    logic [c_cnt_w-1:0] r_cnt;

    logic [1:0]  w_sh;
    logic        w_store;
    logic        w_read;
    logic        w_req;
    logic [3:0]  w_acc_lanes;
    logic [3:0]  w_lanes;
    logic        w_misal;
    logic        w_io;
    logic        w_can_accept;
    logic        w_err_any;
    logic [31:0] w_wdata_sh;
    logic        w_bram_en;
    logic [3:0]  w_bram_we;
    logic [31:0] w_bram_q;
    logic [31:0] w_bram_view;
    logic        w_unused;

    assign w_sh         = bus.mem_addr[1:0];
    assign w_store      = |bus.mem_we;
    assign w_read       = (|bus.mem_oe) && !w_store;
    assign w_req        = w_store || w_read;
    assign w_acc_lanes  = w_store ? bus.mem_we : bus.mem_oe;
    assign w_lanes      = lane_shift(w_acc_lanes, w_sh);
    assign w_misal      = !lane_aligned(w_acc_lanes, w_sh);
    assign w_io         = bus.mem_addr[c_io_sel];
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_RD_DONE);
    assign w_err_any    = r_err_misal || r_err_tmo;
    assign w_wdata_sh   = align_lanes(bus.mem_wdata, w_sh);

    // Upper address bits between the BRAM index and the IO select alias.
    assign w_unused = &{1'b0, bus.mem_addr[30:2+SCALE]};

    // BRAM is driven straight from the request so the write and read both land on the accept edge.
    assign w_bram_en = !rst && w_can_accept && w_req && !w_io && !w_misal;
    assign w_bram_we = w_lanes & {4{w_store}};

    dmem_bram #(
        .SCALE (SCALE)
    ) u_bram (
        .clk   (clk),
        .en    (w_bram_en),
        .we    (w_bram_we),
        .addr  (bus.mem_addr[2 +: SCALE]),
        .wdata (w_wdata_sh),
        .rdata (w_bram_q)
    );

    assign w_bram_view = r_rd_zero ? 32'd0 : align_right(w_bram_q, r_sh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= 1'b0;
            r_ready     <= 1'b1;
            r_rdata     <= '0;
            r_io_req    <= 1'b0;
            r_io_addr   <= '0;
            r_io_wdata  <= '0;
            r_io_we     <= '0;
            r_err_misal <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_err_addr  <= '0;
            r_sh        <= '0;
            r_rd_zero   <= 1'b0;
            r_io_read   <= 1'b0;
            r_req_addr  <= '0;
            r_cnt       <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RD_DONE: begin
                    if (r_state == ST_RD_DONE) begin
                        r_rdata <= w_bram_view;
                    end
                    r_state <= ST_IDLE;
                    if (w_req) begin
                        r_sh <= w_sh;
                        if (w_misal) begin
                            r_err_misal <= 1'b1;
                            if (!w_err_any) begin
                                r_err_addr <= bus.mem_addr;
                            end
                            if (w_read) begin
                                r_rd_zero <= 1'b1;
                                r_valid   <= 1'b1;
                                r_state   <= ST_RD_DONE;
                            end
                        end else if (w_io) begin
                            r_io_req   <= 1'b1;
                            r_io_addr  <= {bus.mem_addr[31:2], 2'b00};
                            r_io_wdata <= w_wdata_sh;
                            r_io_we    <= w_lanes & {4{w_store}};
                            r_io_read  <= w_read;
                            r_req_addr <= bus.mem_addr;
                            r_cnt      <= '0;
                            r_ready    <= 1'b0;
                            r_state    <= ST_IO_WAIT;
                        end else if (w_read) begin
                            r_rd_zero <= 1'b0;
                            r_valid   <= 1'b1;
                            r_state   <= ST_RD_DONE;
                        end
                    end
                end
                ST_IO_WAIT: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (bus.io_ack) begin
                        r_io_req <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_IO_DONE;
                        if (r_io_read) begin
                            r_valid <= 1'b1;
                            r_rdata <= align_right(bus.io_rdata, r_sh);
                        end
                    end else if (r_cnt == c_cnt_max) begin
                        r_io_req  <= 1'b0;
                        r_ready   <= 1'b1;
                        r_err_tmo <= 1'b1;
                        r_state   <= ST_IO_DONE;
                        if (!w_err_any) begin
                            r_err_addr <= r_req_addr;
                        end
                        if (r_io_read) begin
                            r_valid <= 1'b1;
                            r_rdata <= align_right(c_deadbeef, r_sh);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IO_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outside RD_DONE the held register is shown, so rdata stays put between pulses.
    assign bus.mem_rdata = (r_state == ST_RD_DONE) ? w_bram_view : r_rdata;
    assign bus.mem_valid = r_valid;
    assign bus.mem_ready = r_ready;
    assign bus.io_req    = r_io_req;
    assign bus.io_addr   = r_io_addr;
    assign bus.io_wdata  = r_io_wdata;
    assign bus.io_we     = r_io_we;
    assign bus.err_misal = r_err_misal;
    assign bus.err_tmo   = r_err_tmo;
    assign bus.err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// =============================================================================
// Module : tb_data_mem_responder
// Brief  : Directed plus randomized bench with a byte-addressed reference model
// Rev    : 1.0  initial release
// =============================================================================
module tb_data_mem_responder;

    localparam int unsigned SCALE   = 14;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [31:0] BYTES   = 32'(4) << SCALE;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [7:0] mdl_mem [logic [31:0]];

    data_mem_responder_if bus ();

    data_mem_responder #(
        .SCALE   (SCALE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [3:0] oe);
        return $countones(oe);
    endfunction

    function automatic logic [3:0] size_mask(input int n);
        return (n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111;
    endfunction

    function automatic bit is_misal(input logic [31:0] a, input logic [3:0] oe);
        return (a % nbytes(oe)) != 0;
    endfunction

    // Byte-addressed memory: loads return every byte from addr up to the word end.
    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] base;
        logic [31:0] r;
        off  = a % BYTES;
        base = off - (off % 4);
        r    = 32'd0;
        for (int k = 0; k < 4 - int'(off % 4); k++) begin
            r[8*k +: 8] = mdl_mem[base + off % 4 + k];
        end
        return r;
    endfunction

    function automatic void mdl_write(input logic [31:0] a, input logic [3:0] oe, input logic [31:0] wd);
        for (int k = 0; k < nbytes(oe); k++) begin
            mdl_mem[(a % BYTES) + k] = wd[8*k +: 8];
        end
    endfunction

    task automatic drive(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we,
                         input logic [31:0] wd);
        bus.mem_addr  = a;
        bus.mem_oe    = oe;
        bus.mem_we    = we;
        bus.mem_wdata = wd;
        tick();
        bus.mem_oe    = 4'b0000;
        bus.mem_we    = 4'b0000;
        bus.mem_wdata = $urandom;
    endtask

    task automatic bram_store(input logic [31:0] a, input logic [3:0] oe, input logic [31:0] wd);
        drive(a, oe, oe, wd);
        if (!is_misal(a, oe)) mdl_write(a, oe, wd);
        chk("store_no_valid", bus.mem_valid, 1'b0);
        chk("store_ready", bus.mem_ready, 1'b1);
    endtask

    task automatic bram_load(input string tag, input logic [31:0] a, input logic [3:0] oe);
        logic [31:0] exp;
        exp = is_misal(a, oe) ? 32'd0 : mdl_read(a);
        drive(a, oe, 4'b0000, 32'd0);
        chk({tag, "_valid"}, bus.mem_valid, 1'b1);
        chk({tag, "_rdata"}, bus.mem_rdata, exp);
        chk({tag, "_ready"}, bus.mem_ready, 1'b1);
    endtask

    task automatic io_access(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we,
                             input logic [31:0] wd, input int delay, input logic [31:0] rdat);
        int sh;
        sh = int'(a % 4);
        drive(a, oe, we, wd);
        chk("io_req_on", bus.io_req, 1'b1);
        chk("io_addr", bus.io_addr, a - (a % 4));
        chk("io_we", bus.io_we, (we != 0) ? 4'((oe * (1 << sh)) % 16) : 4'b0000);
        if (we != 0) chk("io_wdata", bus.io_wdata, wd * (32'd1 << (8 * sh)));
        chk("io_ready_low", bus.mem_ready, 1'b0);
        repeat (delay) tick();
        chk("io_wait_req", bus.io_req, 1'b1);
        chk("io_wait_ready", bus.mem_ready, 1'b0);
        bus.io_ack   = 1'b1;
        bus.io_rdata = rdat;
        tick();
        bus.io_ack   = 1'b0;
        bus.io_rdata = $urandom;
        chk("io_req_off", bus.io_req, 1'b0);
        chk("io_done_ready", bus.mem_ready, 1'b1);
        chk("io_done_valid", bus.mem_valid, (we == 0) ? 1'b1 : 1'b0);
        if (we == 0) chk("io_rdata", bus.mem_rdata, rdat / (32'd1 << (8 * sh)));
        tick();
        chk("io_after_valid", bus.mem_valid, 1'b0);
    endtask

    task automatic io_timeout(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we,
                              input logic [31:0] wd);
        int n;
        logic [31:0] held;
        held = bus.mem_rdata;
        drive(a, oe, we, wd);
        chk("tmo_io_we", bus.io_we, (we != 0) ? 4'((oe * (1 << (a % 4))) % 16) : 4'b0000);
        if (we != 0) chk("tmo_io_wdata", bus.io_wdata, wd * (32'd1 << (8 * (a % 4))));
        n = 0;
        while (bus.io_req === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        chk("tmo_req_cycles", 32'(n), 32'(TIMEOUT + 1));
        chk("tmo_err", bus.err_tmo, 1'b1);
        chk("tmo_ready", bus.mem_ready, 1'b1);
        chk("tmo_valid", bus.mem_valid, (we == 0) ? 1'b1 : 1'b0);
        chk("tmo_rdata", bus.mem_rdata, (we == 0) ? 32'hDEADBEEF / (32'd1 << (8 * (a % 4))) : held);
        tick();
        chk("tmo_after_valid", bus.mem_valid, 1'b0);
    endtask

    function automatic logic [31:0] mk_addr(input int k, input logic [1:0] sh);
        logic [31:0] a;
        a = {1'b0, 15'($urandom), 14'(128 + k), sh};
        return a;
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] held;
        int          sz;
        int          op;
        logic [1:0]  sh;

        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_oe    = '0;
        bus.mem_we    = '0;
        bus.mem_wdata = '0;
        bus.io_ack    = 1'b0;
        bus.io_rdata  = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", bus.mem_valid, 1'b0);
        chk("rst_ready", bus.mem_ready, 1'b1);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_io_req", bus.io_req, 1'b0);
        chk("rst_io_addr", bus.io_addr, 32'd0);
        chk("rst_io_wdata", bus.io_wdata, 32'd0);
        chk("rst_io_we", bus.io_we, 4'd0);
        chk("rst_err", {bus.err_misal, bus.err_tmo}, 2'b00);
        chk("rst_err_addr", bus.err_addr, 32'd0);

        bram_store(32'h100, 4'b1111, 32'h12345678);
        bram_load("lw100", 32'h100, 4'b1111);
        chk("lw100_exact", bus.mem_rdata, 32'h12345678);
        tick();
        chk("hold_valid", bus.mem_valid, 1'b0);
        chk("hold_rdata", bus.mem_rdata, 32'h12345678);

        bram_store(32'h103, 4'b0001, 32'hAB);
        bram_load("lbu103", 32'h103, 4'b0001);
        chk("lbu103_exact", bus.mem_rdata, 32'h000000AB);
        bram_load("lw100b", 32'h100, 4'b1111);
        chk("lw100b_exact", bus.mem_rdata, 32'hAB345678);

        bram_load("lh101", 32'h101, 4'b0011);
        chk("misal_flag", bus.err_misal, 1'b1);
        chk("misal_addr", bus.err_addr, 32'h101);
        bram_store(32'h102, 4'b1111, 32'hFFFF_FFFF);
        chk("misal_addr_first", bus.err_addr, 32'h101);
        bram_load("lw100c", 32'h100, 4'b1111);
        chk("lw100c_exact", bus.mem_rdata, 32'hAB345678);

        bram_store(32'h0001_0104, 4'b1111, 32'h0BADCAFE);
        bram_load("wrap104", 32'h104, 4'b1111);
        chk("wrap104_exact", bus.mem_rdata, 32'h0BADCAFE);

        io_access(32'h8000_0010, 4'b1111, 4'b0000, 32'd0, 5, 32'hCAFEF00D);
        io_access(32'h8000_0021, 4'b0001, 4'b0000, 32'd0, 2, 32'h11223344);
        io_access(32'h8000_0030, 4'b1111, 4'b0000, 32'd0, TIMEOUT, 32'h5A5A1234);
        chk("ack_wins_no_err", bus.err_tmo, 1'b0);
        io_access(32'h8000_0046, 4'b0011, 4'b0011, 32'h0000_C0DE, 0, 32'd0);

        io_timeout(32'h8000_0002, 4'b0011, 4'b0011, 32'h0000_BEEF);
        chk("tmo_addr_first", bus.err_addr, 32'h101);
        io_timeout(32'h8000_0042, 4'b0011, 4'b0000, 32'd0);

        held = bus.mem_rdata;
        bus.io_ack   = 1'b1;
        bus.io_rdata = 32'h77777777;
        tick();
        bus.io_ack = 1'b0;
        chk("stray_ack_valid", bus.mem_valid, 1'b0);
        chk("stray_ack_rdata", bus.mem_rdata, held);

        for (int k = 0; k < 64; k++) begin
            bram_store(mk_addr(k, 2'b00), 4'b1111, $urandom);
        end
        for (int i = 0; i < 160; i++) begin
            op = int'($urandom_range(0, 9));
            sz = 1 << $urandom_range(0, 2);
            sh = 2'($urandom);
            if (op != 7) sh = sh - 2'(sh % sz);
            a = mk_addr(int'($urandom_range(0, 63)), sh);
            if (op <= 2) begin
                bram_store(a, size_mask(sz), $urandom);
            end else if (op <= 7) begin
                bram_load("rnd_load", a, size_mask(sz));
            end else begin
                a = {1'b1, 29'($urandom), sh};
                if ($urandom_range(0, 1) == 0)
                    io_access(a, size_mask(sz), 4'b0000, 32'd0, int'($urandom_range(0, 8)), $urandom);
                else
                    io_access(a, size_mask(sz), size_mask(sz), $urandom, int'($urandom_range(0, 8)), 32'd0);
            end
        end
        chk("rnd_err_addr", bus.err_addr, 32'h101);

        drive(32'h8000_0080, 4'b1111, 4'b0000, 32'd0);
        repeat (3) tick();
        chk("pre_rst_req", bus.io_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_io_req", bus.io_req, 1'b0);
        chk("midrst_ready", bus.mem_ready, 1'b1);
        chk("midrst_valid", bus.mem_valid, 1'b0);
        chk("midrst_err", {bus.err_misal, bus.err_tmo}, 2'b00);
        bus.io_ack   = 1'b1;
        bus.io_rdata = 32'h99999999;
        tick();
        bus.io_ack = 1'b0;
        chk("late_ack_valid", bus.mem_valid, 1'b0);
        chk("late_ack_rdata", bus.mem_rdata, 32'd0);
        bram_load("post_rst_lw", 32'h100, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
